// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 codes,
// memory size codes and funct3 legality/size helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [1:0] f3_size(input logic [2:0] f3);
    logic [1:0] sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational load-data extender: sign/zero extends right-justified memory data
// according to the load funct3.
module lsu_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data
);

  // Select extension mode from funct3.
  always_comb begin
    data = raw;
    case (funct3)
      F3_B:    data = {{(XLEN-8){raw[7]}}, raw[7:0]};
      F3_H:    data = {{(XLEN-16){raw[15]}}, raw[15:0]};
      F3_BU:   data = {{(XLEN-8){1'b0}}, raw[7:0]};
      F3_HU:   data = {{(XLEN-16){1'b0}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: one request at a time, fixed memory latency, extended load return.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses error out instead of being force-aligned.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd,
  output logic            resp_err,
  output logic            mem_en,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_addr,
  output logic [1:0]      mem_size,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  state_t          state, state_next;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [4:0]      rd_q;
  logic            err_q;
  logic [3:0]      cnt;
  logic [XLEN-1:0] rdata_q;

  logic [1:0]      size_d;
  logic            bad_d;
  logic [XLEN-1:0] addr_d;
  logic [XLEN-1:0] wdata_d;
  logic [XLEN-1:0] ext_data;

  lsu_extend #(.XLEN(XLEN)) u_extend (
    .funct3 (f3_q),
    .raw    (rdata_q),
    .data   (ext_data)
  );

  // Decode of the latched request, consumed in CHECK.
  always_comb begin
    size_d  = f3_size(f3_q);
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (size_d)
      SZ_B: wdata_d = {{(XLEN-8){1'b0}}, wdata_q[7:0]};
      SZ_H: begin
        wdata_d = {{(XLEN-16){1'b0}}, wdata_q[15:0]};
        addr_d  = {addr_q[XLEN-1:1], 1'b0};
      end
      default: addr_d = {addr_q[XLEN-1:2], 2'b00};
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    if (size_d == SZ_H) begin
      bad_d = ~f3_legal(we_q, f3_q) | addr_q[0];
    end else if (size_d == SZ_W) begin
      bad_d = ~f3_legal(we_q, f3_q) | (addr_q[1:0] != 2'b00);
    end else begin
      bad_d = ~f3_legal(we_q, f3_q);
    end
`else
    bad_d = ~f3_legal(we_q, f3_q);
`endif
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) state_next = CHECK;
        else                        state_next = IDLE;
      end
      CHECK: begin
        if (bad_d) state_next = RESP;
        else       state_next = WAIT;
      end
      WAIT: begin
        if (cnt <= 4'd1) state_next = RESP;
        else             state_next = WAIT;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus all registered outputs and request/response datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      we_q       <= 1'b0;
      f3_q       <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 5'd0;
      err_q      <= 1'b0;
      cnt        <= 4'd0;
      rdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_rd    <= 5'd0;
      resp_err   <= 1'b0;
      mem_en     <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_size   <= 2'b00;
      mem_wdata  <= '0;
    end else begin
      state      <= state_next;
      req_ready  <= (state_next == IDLE);
      mem_en     <= 1'b0;
      mem_wen    <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_rd    <= 5'd0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
          end
        end
        CHECK: begin
          err_q <= bad_d;
          if (!bad_d) begin
            mem_en    <= 1'b1;
            mem_wen   <= we_q;
            mem_addr  <= addr_d;
            mem_size  <= size_d;
            mem_wdata <= wdata_d;
            cnt       <= LAT_INIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) rdata_q <= mem_rdata;
        end
        RESP: begin
          resp_valid <= 1'b1;
          resp_err   <= err_q;
          if (!err_q && !we_q) begin
            resp_data <= ext_data;
            resp_rd   <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: two instances (MEM_LAT 1 and 4) share request
// fields; a latency-aware memory responder feeds each; a byte-level model predicts results.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic [31:0] rd_val = 32'd0;

  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_data  [2];
  logic [4:0]  resp_rd    [2];
  logic        resp_err   [2];
  logic        mem_en     [2];
  logic        mem_wen    [2];
  logic [31:0] mem_addr   [2];
  logic [1:0]  mem_size   [2];
  logic [31:0] mem_wdata  [2];
  logic [31:0] mem_rdata  [2];
  int          age        [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_LAT(1), .XLEN(32)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(resp_valid[0]),
    .resp_data(resp_data[0]), .resp_rd(resp_rd[0]), .resp_err(resp_err[0]),
    .mem_en(mem_en[0]), .mem_wen(mem_wen[0]), .mem_addr(mem_addr[0]),
    .mem_size(mem_size[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  lsu_ctrl #(.MEM_LAT(4), .XLEN(32)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(resp_valid[1]),
    .resp_data(resp_data[1]), .resp_rd(resp_rd[1]), .resp_err(resp_err[1]),
    .mem_en(mem_en[1]), .mem_wen(mem_wen[1]), .mem_addr(mem_addr[1]),
    .mem_size(mem_size[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // Memory: read data is valid only in the MEM_LAT-th cycle after the strobe, noise otherwise.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst) age[i] = 0;
      else if (mem_en[i]) age[i] = 1;
      else if (age[i] != 0 && age[i] < lat_of(i)) age[i] = age[i] + 1;
      else age[i] = 0;
      mem_rdata[i] = (age[i] == lat_of(i) && age[i] != 0) ? rd_val : $urandom;
    end
  end

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (req_ready[i] !== 1'b1) begin
        errors++;
        $display("FAIL %s dut%0d req_ready: got %b want 1", tag, i, req_ready[i]);
      end
      checks++;
      if ({resp_valid[i], resp_err[i], mem_en[i], mem_wen[i], mem_size[i], resp_rd[i]} !== 11'd0) begin
        errors++;
        $display("FAIL %s dut%0d ctrl outputs: got %b want 0", tag, i,
                 {resp_valid[i], resp_err[i], mem_en[i], mem_wen[i], mem_size[i], resp_rd[i]});
      end
      checks++;
      if ({resp_data[i], mem_addr[i], mem_wdata[i]} !== 96'd0) begin
        errors++;
        $display("FAIL %s dut%0d data outputs: got %h want 0", tag, i,
                 {resp_data[i], mem_addr[i], mem_wdata[i]});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
  endtask

  // One request issued to both units; both are checked against the model.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdval);
    logic        legal, mis, bad;
    longint      nbytes, m, raw;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [1:0]  e_size;
    logic [4:0]  e_rd;
    int          e_lat;
    bit          done [2];
    int          en_cnt [2];
    logic [31:0] s_addr [2];
    logic [31:0] s_wdata [2];
    logic [1:0]  s_size [2];
    logic        s_wen [2];

    legal  = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    nbytes = longint'(1) << f3[1:0];
    mis    = (longint'(addr) % nbytes) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    bad = !legal || mis;
`else
    bad = !legal;
`endif
    m       = longint'(1) << (8 * nbytes);
    e_addr  = addr - 32'(longint'(addr) % nbytes);
    e_size  = (nbytes == 1) ? 2'd0 : (nbytes == 2) ? 2'd1 : 2'd2;
    e_wdata = 32'(longint'(wdata) % m);
    raw     = longint'(rdval) % m;
    if (!f3[2] && nbytes < 4 && raw >= m / 2) raw = raw + ((longint'(1) << 32) - m);
    e_data  = (bad || we) ? 32'd0 : 32'(raw);
    e_rd    = (bad || we) ? 5'd0 : rd;

    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (req_ready[i] !== 1'b1) begin
        errors++;
        $display("FAIL ready_before dut%0d: got %b want 1", i, req_ready[i]);
      end
    end
    rd_val = rdval; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
    req_valid[0] = 1'b1;
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    // Keep req_valid asserted with junk fields while busy: it must be ignored.
    req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_rd = 5'($urandom);
    for (int i = 0; i < 2; i++) begin
      done[i] = 1'b0; en_cnt[i] = 0;
      s_addr[i] = 32'd0; s_wdata[i] = 32'd0; s_size[i] = 2'd0; s_wen[i] = 1'b0;
    end
    for (int k = 1; k <= 40 && !(done[0] && done[1]); k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (!done[i]) begin
          if (mem_en[i]) begin
            en_cnt[i]++;
            s_addr[i] = mem_addr[i]; s_wdata[i] = mem_wdata[i];
            s_size[i] = mem_size[i]; s_wen[i] = mem_wen[i];
          end
          if (resp_valid[i]) begin
            done[i] = 1'b1;
            req_valid[i] = 1'b0;
            e_lat = bad ? 2 : 2 + lat_of(i);
            checks++;
            if (k !== e_lat) begin
              errors++;
              $display("FAIL latency dut%0d f3=%0d: got %0d want %0d", i, f3, k, e_lat);
            end
            checks++;
            if (resp_err[i] !== bad) begin
              errors++;
              $display("FAIL resp_err dut%0d f3=%0d addr=%h: got %b want %b", i, f3, addr, resp_err[i], bad);
            end
            checks++;
            if (resp_data[i] !== e_data) begin
              errors++;
              $display("FAIL resp_data dut%0d f3=%0d: got %h want %h", i, f3, resp_data[i], e_data);
            end
            checks++;
            if (resp_rd[i] !== e_rd) begin
              errors++;
              $display("FAIL resp_rd dut%0d: got %0d want %0d", i, resp_rd[i], e_rd);
            end
          end else begin
            checks++;
            if (req_ready[i] !== 1'b0) begin
              errors++;
              $display("FAIL busy_ready dut%0d cycle %0d: got 1 want 0", i, k);
            end
          end
        end
      end
    end
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (!done[i]) begin
        errors++;
        $display("FAIL timeout dut%0d: resp_valid not seen, want within 40 cycles", i);
      end
      checks++;
      if (en_cnt[i] !== (bad ? 0 : 1)) begin
        errors++;
        $display("FAIL mem_en_count dut%0d: got %0d want %0d", i, en_cnt[i], bad ? 0 : 1);
      end
      if (!bad) begin
        checks++;
        if ({s_addr[i], s_size[i], s_wen[i]} !== {e_addr, e_size, we}) begin
          errors++;
          $display("FAIL mem_access dut%0d: got addr=%h size=%0d wen=%b want addr=%h size=%0d wen=%b",
                   i, s_addr[i], s_size[i], s_wen[i], e_addr, e_size, we);
        end
        if (we) begin
          checks++;
          if (s_wdata[i] !== e_wdata) begin
            errors++;
            $display("FAIL mem_wdata dut%0d: got %h want %h", i, s_wdata[i], e_wdata);
          end
        end
      end
    end
  endtask

  task automatic test_directed();
    run_req(1'b0, 3'b000, 32'h10, 32'h0, 5'd3, 32'h0000_00F0);
    run_req(1'b0, 3'b101, 32'h22, 32'h0, 5'd17, 32'h0000_BEEF);
    run_req(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 5'd9, 32'h1234_5678);
    run_req(1'b0, 3'b011, 32'h80, 32'h0, 5'd4, 32'h1111_1111);
    run_req(1'b0, 3'b010, 32'h43, 32'h0, 5'd5, 32'hCAFE_F00D);
    run_req(1'b1, 3'b000, 32'h51, 32'hAABB_CCDD, 5'd1, 32'h0);
    run_req(1'b1, 3'b001, 32'h52, 32'hAABB_CCDD, 5'd1, 32'h0);
    run_req(1'b0, 3'b001, 32'h60, 32'h0, 5'd31, 32'h0000_8001);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_req(1'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom), $urandom);
    end
  endtask

  task automatic test_reset_abort();
    @(posedge clk);
    #1;
    rd_val = 32'h7777_7777; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h100; req_wdata = 32'h0; req_rd = 5'd12;
    req_valid[0] = 1'b1;
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_values("abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (resp_valid[i] !== 1'b0) begin
          errors++;
          $display("FAIL abort_no_resp dut%0d cycle %0d: got 1 want 0", i, k);
        end
      end
    end
    run_req(1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 32'h0000_00A5);
  endtask

  initial begin
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
